// File: rtl/hawk_pg_reader_if.sv
// hawk_pg_reader_if: page request, AXI4 read channels and page-buffer beat stream
interface hawk_pg_reader_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH = 4,
  parameter int IDX_W = 6
);
  logic req_valid;
  logic req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic done;
  logic err;
  logic [ID_WIDTH-1:0] m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst;
  logic m_arvalid;
  logic m_arready;
  logic [ID_WIDTH-1:0] m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0] m_rresp;
  logic m_rlast;
  logic m_rvalid;
  logic m_rready;
  logic pg_valid;
  logic pg_ready;
  logic [DATA_WIDTH-1:0] pg_data;
  logic [IDX_W-1:0] pg_idx;
  modport master (
    input req_valid, req_addr, m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, pg_ready,
    output req_ready, done, err, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    m_rready, pg_valid, pg_data, pg_idx
  );
  modport slave (
    output req_valid, req_addr, m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, pg_ready,
    input req_ready, done, err, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    m_rready, pg_valid, pg_data, pg_idx
  );
endinterface

// File: rtl/hawk_pg_reader.sv
// hawk_pg_reader: fetches one page over AXI4 read as fixed INCR bursts and streams indexed beats to the page buffer
module hawk_pg_reader #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH = 4,
  parameter int PAGE_SIZE = 4096,
  parameter int BURST_BEATS = 16,
  parameter logic [ID_WIDTH-1:0] RD_ID = '0
) (
  input logic clk_i,
  input logic rst_i,
  hawk_pg_reader_if.master bus
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int PAGE_BEATS = PAGE_SIZE / BPB;
  localparam int IDX_W = $clog2(PAGE_BEATS);
  localparam int PG_W = $clog2(PAGE_SIZE);
  localparam int SZ_W = $clog2(BPB);
  localparam logic [IDX_W-1:0] BMASK = IDX_W'(BURST_BEATS - 1);
  typedef enum logic [1:0] {IDLE, AR, RD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0] beat_cnt;
  logic err_q;
  logic rx;
  logic burst_end;
  logic page_end;
  logic unused_ok;
  assign unused_ok = ^{bus.m_rid, bus.req_addr[PG_W-1:0]};
  assign rx = state == RD && bus.m_rvalid && bus.pg_ready;
  // burst and page boundaries come from the page-relative beat count alone; RLAST is only checked
  assign burst_end = (beat_cnt & BMASK) == BMASK;
  assign page_end = &beat_cnt;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // page base, beat counter and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      base <= '0;
      beat_cnt <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      base <= {bus.req_addr[ADDR_WIDTH-1:PG_W], PG_W'(0)};
      beat_cnt <= '0;
      err_q <= 1'b0;
    end else if (rx) begin
      beat_cnt <= beat_cnt + 1'b1;
      err_q <= err_q | (|bus.m_rresp) | (bus.m_rlast != burst_end);
    end
  // next state and outputs; the burst address tracks beat_cnt, which sits on a burst boundary in AR
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.req_valid) state_nx = AR;
    if (state == AR && bus.m_arready) state_nx = RD;
    if (rx && burst_end) state_nx = page_end ? DONE : AR;
    if (state == DONE) state_nx = IDLE;
    bus.req_ready = state == IDLE;
    bus.m_arvalid = state == AR;
    bus.m_araddr = base + (ADDR_WIDTH'(beat_cnt) << SZ_W);
    bus.m_arid = RD_ID;
    bus.m_arlen = 8'(BURST_BEATS - 1);
    bus.m_arsize = 3'(SZ_W);
    bus.m_arburst = 2'b01;
    bus.m_rready = state == RD && bus.pg_ready;
    bus.pg_valid = state == RD && bus.m_rvalid;
    bus.pg_data = bus.m_rdata;
    bus.pg_idx = beat_cnt;
    bus.done = state == DONE;
    bus.err = state == DONE && err_q;
  end
endmodule
